// File: rtl/isa_ctrl_pkg.sv
// isa_ctrl_pkg
// Shared types and constants for the ISA bus cycle sequencer:
//   state_e       - bus cycle FSM states
//   strobe_sel_e  - command strobe selection, encoded as {io, write}
//   DEF_*         - default wait-state and ready-timeout settings
//   ISA_FLOAT_DATA- value returned when a cycle is forced to complete
//   strobe_lows() - maps a strobe selection to an active-high strobe mask
package isa_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_TW,
    ST_T4,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    SEL_MEMR = 2'b00,
    SEL_MEMW = 2'b01,
    SEL_IOR  = 2'b10,
    SEL_IOW  = 2'b11
  } strobe_sel_e;

  localparam int DEF_IO_WAIT     = 1;
  localparam int DEF_MEM_WAIT    = 0;
  localparam int DEF_RDY_TIMEOUT = 255;

  localparam int WAIT_W = 8;
  localparam int TMO_W  = 16;

  localparam logic [7:0] ISA_FLOAT_DATA = 8'hFF;

  // Mask bit order is {memw, memr, iow, ior}; a set bit means that strobe is asserted.
  function automatic logic [3:0] strobe_lows(input strobe_sel_e sel);
    case (sel)
      SEL_MEMR: strobe_lows = 4'b0100;
      SEL_MEMW: strobe_lows = 4'b1000;
      SEL_IOR:  strobe_lows = 4'b0001;
      SEL_IOW:  strobe_lows = 4'b0010;
      default:  strobe_lows = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/isa_bus_cycle_ctrl_if.sv
// isa_bus_cycle_ctrl_if
// Request/response channel between a host agent and the ISA bus cycle sequencer.
//   req_valid/req_ready - single-transfer handshake
//   req_write, req_io   - cycle kind (1=write / 1=I/O)
//   req_addr, req_wdata - 20-bit address, 8-bit write data
//   rsp_valid           - one-cycle completion pulse
//   rsp_rdata           - read data, valid with rsp_valid
//   rsp_timeout         - completion was forced, valid with rsp_valid
// Modports: master (host side), slave (sequencer side).
interface isa_bus_cycle_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_write, req_io, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout
  );

  modport slave (
    input  req_valid, req_write, req_io, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout
  );

endinterface

// File: rtl/isa_bus_cycle_ctrl_wait_timer.sv
// isa_wait_timer
// Wait-state bookkeeping for one ISA bus cycle.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - high in T2: load the mandatory wait count, clear the ready timer
//   load_value  - mandatory wait states for this cycle
//   count_en    - high in T3/TW: mandatory counter decrements while nonzero
//   in_tw       - high in TW
//   rdy         - IO_CH_RDY from the slot
//   wait_done   - mandatory wait count has expired
//   timed_out   - IO_CH_RDY held low for RDY_TIMEOUT consecutive TW cycles
// Optional macro ISA_RDY_TIMEOUT_EN enables the ready timeout; otherwise timed_out is 0.
module isa_wait_timer
  import isa_ctrl_pkg::*;
#(
  parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_value,
  input  logic              count_en,
  input  logic              in_tw,
  input  logic              rdy,
  output logic              wait_done,
  output logic              timed_out
);

  logic [WAIT_W-1:0] wait_cnt;

  // The decrement happens in T3 as well as TW so that the count already
  // reflects the TW cycle being entered; N mandatory waits give N TW cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (load) begin
      wait_cnt <= load_value;
    end else if (count_en && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign wait_done = (wait_cnt == '0);

`ifdef ISA_RDY_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RDY_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts TW cycles with ready low; the current low cycle is the one that
  // reaches the limit, so the compare is against RDY_TIMEOUT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (load || rdy) begin
      tmo_cnt <= '0;
    end else if (in_tw) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timed_out = in_tw && !rdy && (tmo_cnt == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = in_tw ^ (RDY_TIMEOUT == 0);
  assign timed_out  = 1'b0;
`endif

endmodule

// File: rtl/isa_bus_cycle_ctrl.sv
// isa_bus_cycle_ctrl
// Host-side bus cycle sequencer for the 8-bit ISA slot. Runs one transfer at a
// time through T1 (ALE), T2/T3 (strobe low), optional TW waits and T4 (response),
// and hands the bus to a DMA controller on request.
//   bus_clk, bus_reset_n     - clock, asynchronous active-low reset
//   req                      - request/response channel (slave modport)
//   busy                     - sequencer is not idle
//   dma_hold_req/ack         - DMA bus hold handshake
//   bus_oe                   - sequencer drives bus_sa and strobes
//   bus_sa, bus_ale, bus_aen - address, address latch enable, address enable
//   bus_ior_n/iow_n/memr_n/memw_n - active-low command strobes
//   bus_io_ch_rdy            - channel ready, low inserts waits
//   sd_in, sd_out, sd_oe     - data bus sample, drive value, output enable
// Optional macro ISA_RDY_TIMEOUT_EN forces completion after RDY_TIMEOUT ready-low waits.
module isa_bus_cycle_ctrl
  import isa_ctrl_pkg::*;
#(
  parameter int IO_WAIT     = DEF_IO_WAIT,
  parameter int MEM_WAIT    = DEF_MEM_WAIT,
  parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT
) (
  input  logic                       bus_clk,
  input  logic                       bus_reset_n,
  isa_bus_cycle_ctrl_if.slave        req,
  output logic                       busy,
  input  logic                       dma_hold_req,
  output logic                       dma_hold_ack,
  output logic                       bus_oe,
  output logic [19:0]                bus_sa,
  output logic                       bus_ale,
  output logic                       bus_aen,
  output logic                       bus_ior_n,
  output logic                       bus_iow_n,
  output logic                       bus_memr_n,
  output logic                       bus_memw_n,
  input  logic                       bus_io_ch_rdy,
  input  logic [7:0]                 sd_in,
  output logic [7:0]                 sd_out,
  output logic                       sd_oe
);

  state_e      state_q, state_d;
  logic [19:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        io_q;
  logic [7:0]  rdata_q;
  logic        timeout_q;

  logic        accept;
  logic        complete;
  logic        wait_done;
  logic        timed_out;
  logic        active;
  logic [3:0]  lows;

  // Ready is gated by reset so no request can be taken while reset is held.
  assign req.req_ready = bus_reset_n && (state_q == ST_IDLE) && !dma_hold_req;
  assign accept        = req.req_valid && req.req_ready;

  // A cycle finishes either normally (wait count expired and channel ready)
  // or, when enabled, because the ready timeout fired in TW.
  assign complete = ((state_q == ST_T3) && wait_done && bus_io_ch_rdy) ||
                    ((state_q == ST_TW) && (timed_out || (wait_done && bus_io_ch_rdy)));

  isa_wait_timer #(
    .RDY_TIMEOUT (RDY_TIMEOUT)
  ) u_wait_timer (
    .clk        (bus_clk),
    .rst_n      (bus_reset_n),
    .load       (state_q == ST_T2),
    .load_value (io_q ? WAIT_W'(IO_WAIT) : WAIT_W'(MEM_WAIT)),
    .count_en   ((state_q == ST_T3) || (state_q == ST_TW)),
    .in_tw      (state_q == ST_TW),
    .rdy        (bus_io_ch_rdy),
    .wait_done  (wait_done),
    .timed_out  (timed_out)
  );

  // State register.
  always_ff @(posedge bus_clk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture on the accept edge; the bus cycle runs from these copies.
  always_ff @(posedge bus_clk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      io_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= req.req_addr;
      wdata_q <= req.req_wdata;
      write_q <= req.req_write;
      io_q    <= req.req_io;
    end
  end

  // Response data is captured on the edge leaving T3/TW so it is stable for
  // the whole T4 pulse; writes leave the previous read data untouched.
  always_ff @(posedge bus_clk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else if (complete) begin
      timeout_q <= timed_out;
      if (!write_q) begin
        rdata_q <= timed_out ? ISA_FLOAT_DATA : sd_in;
      end
    end
  end

  // Next-state logic. DMA hold is only honoured from IDLE so a started bus
  // cycle always runs to T4.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dma_hold_req) begin
          state_d = ST_HOLD;
        end else if (accept) begin
          state_d = ST_T1;
        end
      end
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = complete ? ST_T4 : ST_TW;
      ST_TW:   state_d = complete ? ST_T4 : ST_TW;
      ST_T4:   state_d = ST_IDLE;
      ST_HOLD: state_d = dma_hold_req ? ST_HOLD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so a reset releases the strobes
  // immediately rather than on the next clock.
  always_comb begin
    bus_oe       = 1'b1;
    bus_aen      = 1'b0;
    bus_ale      = 1'b0;
    bus_sa       = '0;
    sd_oe        = 1'b0;
    sd_out       = '0;
    dma_hold_ack = 1'b0;
    lows         = 4'b0000;
    active       = (state_q == ST_T1) || (state_q == ST_T2) || (state_q == ST_T3) ||
                   (state_q == ST_TW) || (state_q == ST_T4);

    if (active) begin
      bus_sa = addr_q;
      if (write_q) begin
        sd_oe  = 1'b1;
        sd_out = wdata_q;
      end
    end

    case (state_q)
      ST_T1:                 bus_ale = 1'b1;
      ST_T2, ST_T3, ST_TW:   lows    = strobe_lows(strobe_sel_e'({io_q, write_q}));
      ST_HOLD: begin
        dma_hold_ack = 1'b1;
        bus_oe       = 1'b0;
        bus_aen      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_ior_n  = ~lows[0];
  assign bus_iow_n  = ~lows[1];
  assign bus_memr_n = ~lows[2];
  assign bus_memw_n = ~lows[3];

  assign busy            = (state_q != ST_IDLE);
  assign req.rsp_valid   = (state_q == ST_T4);
  assign req.rsp_rdata   = rdata_q;
  assign req.rsp_timeout = timeout_q;

endmodule

// File: tb/tb_isa_bus_cycle_ctrl.sv
// tb_isa_bus_cycle_ctrl
// Directed bench for isa_bus_cycle_ctrl. Requests push their hand-computed
// response (data, timeout flag, response cycle, strobe and data-bus activity)
// into a queue; a negedge monitor accumulates bus activity and checks it
// against the queue head whenever rsp_valid is seen.
// Define ISA_RDY_TIMEOUT_EN to also exercise the ready timeout.
module tb_isa_bus_cycle_ctrl;
  import isa_ctrl_pkg::*;

  localparam int TMO = 8;

  logic        bus_clk = 1'b0;
  logic        bus_reset_n = 1'b0;
  logic        busy;
  logic        dma_hold_req = 1'b0;
  logic        dma_hold_ack;
  logic        bus_oe;
  logic [19:0] bus_sa;
  logic        bus_ale;
  logic        bus_aen;
  logic        bus_ior_n, bus_iow_n, bus_memr_n, bus_memw_n;
  logic        bus_io_ch_rdy = 1'b1;
  logic [7:0]  sd_in = 8'h00;
  logic [7:0]  sd_out;
  logic        sd_oe;

  isa_bus_cycle_ctrl_if rq();

  isa_bus_cycle_ctrl #(
    .IO_WAIT     (1),
    .MEM_WAIT    (0),
    .RDY_TIMEOUT (TMO)
  ) dut (
    .bus_clk       (bus_clk),
    .bus_reset_n   (bus_reset_n),
    .req           (rq),
    .busy          (busy),
    .dma_hold_req  (dma_hold_req),
    .dma_hold_ack  (dma_hold_ack),
    .bus_oe        (bus_oe),
    .bus_sa        (bus_sa),
    .bus_ale       (bus_ale),
    .bus_aen       (bus_aen),
    .bus_ior_n     (bus_ior_n),
    .bus_iow_n     (bus_iow_n),
    .bus_memr_n    (bus_memr_n),
    .bus_memw_n    (bus_memw_n),
    .bus_io_ch_rdy (bus_io_ch_rdy),
    .sd_in         (sd_in),
    .sd_out        (sd_out),
    .sd_oe         (sd_oe)
  );

  always #5 bus_clk = ~bus_clk;

  typedef struct {
    logic [7:0]  rdata;
    logic        timeout;
    int          resp_cyc;
    int          strb_cnt;
    logic [3:0]  strb_mask;
    logic [19:0] sa;
    int          oe_cnt;
    logic        write;
    logic [7:0]  wdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge bus_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: accumulates what the bus did during the current transfer and
  // compares it with the queue head on each response pulse.
  int          m_strb, m_ale, m_oe;
  logic [3:0]  m_mask;
  logic [19:0] m_sa;
  logic [7:0]  m_sd;
  exp_t        m_e;

  always @(negedge bus_clk) begin
    if (!bus_reset_n) begin
      m_strb = 0; m_ale = 0; m_oe = 0; m_mask = '0; m_sa = '0; m_sd = '0;
    end else begin
      if ({bus_memw_n, bus_memr_n, bus_iow_n, bus_ior_n} != 4'hF) begin
        m_strb++;
        m_mask = m_mask | ~{bus_memw_n, bus_memr_n, bus_iow_n, bus_ior_n};
      end
      if (bus_ale) begin
        m_ale++;
        m_sa = bus_sa;
      end
      if (sd_oe) begin
        m_oe++;
        m_sd = sd_out;
      end
      if (rq.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          checkOutput("rsp_rdata",   rq.rsp_rdata, m_e.rdata);
          checkOutput("rsp_timeout", rq.rsp_timeout, m_e.timeout);
          checkOutput("rsp_cycle",   cyc, m_e.resp_cyc);
          checkOutput("strobe_low_cycles", m_strb, m_e.strb_cnt);
          checkOutput("strobe_select", m_mask, m_e.strb_mask);
          checkOutput("ale_cycles", m_ale, 1);
          checkOutput("ale_addr", m_sa, m_e.sa);
          checkOutput("sd_oe_cycles", m_oe, m_e.oe_cnt);
          if (m_e.write) checkOutput("sd_out", m_sd, m_e.wdata);
        end
        m_strb = 0; m_ale = 0; m_oe = 0; m_mask = '0;
      end
    end
  end

  // Issues one request and, when push is set, queues its expected response.
  // tw is the number of TW cycles the transfer is expected to take.
  task automatic applyStimulus(input logic write, input logic io, input logic [19:0] addr,
                               input logic [7:0] wdata, input logic [7:0] rdin, input int tw,
                               input logic [7:0] exp_rdata, input logic exp_to,
                               input logic push, output int acc);
    exp_t e;
    int   budget;
    sd_in        = rdin;
    rq.req_write = write;
    rq.req_io    = io;
    rq.req_addr  = addr;
    rq.req_wdata = wdata;
    rq.req_valid = 1'b1;
    budget = 0;
    while (!rq.req_ready && budget < 100) begin
      @(negedge bus_clk);
      budget++;
    end
    if (!rq.req_ready) begin
      checkOutput("accept_wait", 32'd0, 32'd1);
      rq.req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge bus_clk);
    #1;
    acc = cyc;
    rq.req_valid = 1'b0;
    if (push) begin
      e.rdata     = exp_rdata;
      e.timeout   = exp_to;
      e.resp_cyc  = acc + 4 + tw - 1;
      e.strb_cnt  = 2 + tw;
      e.strb_mask = io ? (write ? 4'b0010 : 4'b0001) : (write ? 4'b1000 : 4'b0100);
      e.sa        = addr;
      e.oe_cnt    = write ? 4 + tw : 0;
      e.write     = write;
      e.wdata     = wdata;
      exp_q.push_back(e);
    end
  endtask

  task automatic waitIdle();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge bus_clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("rsp_wait", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge bus_clk);
  endtask

  initial begin
    int acc;
    int d;
    rq.req_valid = 1'b0;
    rq.req_write = 1'b0;
    rq.req_io    = 1'b0;
    rq.req_addr  = '0;
    rq.req_wdata = '0;

    // Reset values while reset is held.
    repeat (2) @(negedge bus_clk);
    checkOutput("rst_strobes", {bus_memw_n, bus_memr_n, bus_iow_n, bus_ior_n}, 4'hF);
    checkOutput("rst_ale", bus_ale, 0);
    checkOutput("rst_aen", bus_aen, 0);
    checkOutput("rst_bus_oe", bus_oe, 1);
    checkOutput("rst_sa", bus_sa, 0);
    checkOutput("rst_sd_oe", sd_oe, 0);
    checkOutput("rst_sd_out", sd_out, 0);
    checkOutput("rst_rsp_valid", rq.rsp_valid, 0);
    checkOutput("rst_rsp_timeout", rq.rsp_timeout, 0);
    checkOutput("rst_rsp_rdata", rq.rsp_rdata, 0);
    checkOutput("rst_hold_ack", dma_hold_ack, 0);
    checkOutput("rst_req_ready", rq.req_ready, 0);
    checkOutput("rst_busy", busy, 0);
    bus_reset_n = 1'b1;
    @(negedge bus_clk);
    checkOutput("idle_ready", rq.req_ready, 1);

    // I/O read, one mandatory wait.
    applyStimulus(1'b0, 1'b1, 20'h003DA, 8'h00, 8'h5A, 1, 8'h5A, 1'b0, 1'b1, acc);
    waitIdle();

    // Memory write, no waits; read data keeps its previous value.
    applyStimulus(1'b1, 1'b0, 20'hB8000, 8'h41, 8'hEE, 0, 8'h5A, 1'b0, 1'b1, acc);
    waitIdle();

    // Memory read, no waits.
    applyStimulus(1'b0, 1'b0, 20'h12345, 8'h00, 8'hC3, 0, 8'hC3, 1'b0, 1'b1, acc);
    waitIdle();

    // I/O write with ready held low for the six decisions after T2.
    bus_io_ch_rdy = 1'b0;
    applyStimulus(1'b1, 1'b1, 20'h002F8, 8'h99, 8'h00, 6, 8'hC3, 1'b0, 1'b1, acc);
    repeat (8) @(posedge bus_clk);
    #1 bus_io_ch_rdy = 1'b1;
    waitIdle();

    // DMA hold wins over a simultaneous request.
    rq.req_write = 1'b0;
    rq.req_io    = 1'b1;
    rq.req_addr  = 20'h00060;
    dma_hold_req = 1'b1;
    rq.req_valid = 1'b1;
    @(posedge bus_clk);
    @(negedge bus_clk);
    checkOutput("hold_ack", dma_hold_ack, 1);
    checkOutput("hold_aen", bus_aen, 1);
    checkOutput("hold_bus_oe", bus_oe, 0);
    checkOutput("hold_ready", rq.req_ready, 0);
    checkOutput("hold_busy", busy, 1);
    checkOutput("hold_strobes", {bus_memw_n, bus_memr_n, bus_iow_n, bus_ior_n}, 4'hF);
    repeat (3) @(negedge bus_clk);
    checkOutput("hold_sticky", dma_hold_ack, 1);
    dma_hold_req = 1'b0;
    d = cyc;
    applyStimulus(1'b0, 1'b1, 20'h00060, 8'h00, 8'h77, 1, 8'h77, 1'b0, 1'b1, acc);
    checkOutput("accept_after_hold", acc, d + 2);
    waitIdle();

`ifdef ISA_RDY_TIMEOUT_EN
    // Ready stuck low: forced completion with floating-bus data.
    bus_io_ch_rdy = 1'b0;
    applyStimulus(1'b0, 1'b1, 20'h00300, 8'h00, 8'h12, TMO, 8'hFF, 1'b1, 1'b1, acc);
    waitIdle();
    bus_io_ch_rdy = 1'b1;
    applyStimulus(1'b0, 1'b0, 20'h0ABCD, 8'h00, 8'h3C, 0, 8'h3C, 1'b0, 1'b1, acc);
    waitIdle();
`endif

    // Reset in the middle of a read's wait state: no response is produced.
    bus_io_ch_rdy = 1'b0;
    applyStimulus(1'b0, 1'b1, 20'h00201, 8'h00, 8'h55, 0, 8'h00, 1'b0, 1'b0, acc);
    repeat (4) @(posedge bus_clk);
    #2;
    checkOutput("pre_reset_ior", bus_ior_n, 0);
    bus_reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_strobes", {bus_memw_n, bus_memr_n, bus_iow_n, bus_ior_n}, 4'hF);
    checkOutput("mid_reset_busy", busy, 0);
    checkOutput("mid_reset_rsp_valid", rq.rsp_valid, 0);
    checkOutput("mid_reset_rdata", rq.rsp_rdata, 0);
    repeat (2) @(negedge bus_clk);
    bus_reset_n   = 1'b1;
    bus_io_ch_rdy = 1'b1;
    repeat (3) @(negedge bus_clk);
    checkOutput("post_reset_busy", busy, 0);
    checkOutput("post_reset_ready", rq.req_ready, 1);

    // Normal operation after the aborted cycle.
    applyStimulus(1'b0, 1'b1, 20'h003F8, 8'h00, 8'hA5, 1, 8'hA5, 1'b0, 1'b1, acc);
    waitIdle();
    repeat (3) @(negedge bus_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
